// File: rtl/dmem_responder.sv
// Data-side memory responder for the RV64 core: byte-laned RAM plus a small MMIO
// block (console TX FIFO with a valid/ready byte output, and a sticky tohost halt register).
module dmem_responder #(
    parameter int          MEM_WORDS  = 4096,
    parameter logic [63:0] MMIO_BASE  = 64'h0000_0000_1000_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] addr,
    input  logic [63:0] writeData,
    input  logic        memWrite,
    input  logic [2:0]  memType,
    output logic [63:0] readData,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        halt,
    output logic [31:0] halt_code
);
    localparam int          AW       = $clog2(MEM_WORDS);
    localparam int          PW       = $clog2(FIFO_DEPTH);
    localparam int          CW       = PW + 1;
    localparam logic [63:0] MMIO_END = MMIO_BASE + 64'h1_0000;

    typedef enum logic {IDLE, SEND} state_t;

    state_t         state_q, state_d;
    logic [63:0]    mem [MEM_WORDS];
    logic [7:0]     fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]  rd_ptr, wr_ptr;
    logic [CW-1:0]  count;
    logic           overflow;
    logic           is_ram, is_mmio, ram_we, push_req, push_ok, pop, tohost_we;
    logic           full, empty;
    logic [AW-1:0]  ram_idx;
    logic [12:0]    mmio_word;
    logic [2:0]     lane;
    logic [7:0]     size_mask, wmask;
    logic [63:0]    wdata_sh, rd_word, rd_sh, status;
    logic [3:0]     cnt4;

    assign is_ram    = addr < MMIO_BASE;
    assign is_mmio   = (addr >= MMIO_BASE) && (addr < MMIO_END);
    assign ram_idx   = addr[3 +: AW];
    // MMIO registers are decoded per 64-bit word so lane selection works like RAM.
    assign mmio_word = addr[15:3];
    assign ram_we    = memWrite && is_ram;
    assign push_req  = memWrite && is_mmio && (mmio_word == 13'd0);
    assign tohost_we = memWrite && is_mmio && (mmio_word == 13'd2);

    always_comb begin
        lane      = 3'b000;
        size_mask = 8'hFF;
        case (memType[1:0])
            2'b00: begin lane = addr[2:0];          size_mask = 8'h01; end
            2'b01: begin lane = {addr[2:1], 1'b0};  size_mask = 8'h03; end
            2'b10: begin lane = {addr[2], 2'b00};   size_mask = 8'h0F; end
            default: begin lane = 3'b000;           size_mask = 8'hFF; end
        endcase
    end

    assign wmask    = size_mask << lane;
    assign wdata_sh = writeData << {lane, 3'b000};

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 8; i++) begin
                if (wmask[i]) mem[ram_idx][i*8 +: 8] <= wdata_sh[i*8 +: 8];
            end
        end
    end

    assign full   = (count == CW'(FIFO_DEPTH));
    assign empty  = (count == '0);
    assign cnt4   = 4'(count);
    assign status = {56'b0, cnt4, 1'b0, overflow, empty, full};

    always_comb begin
        rd_word = '0;
        if (is_ram) begin
            rd_word = mem[ram_idx];
        end else if (is_mmio) begin
            case (mmio_word)
                13'd1:   rd_word = status;
                13'd2:   rd_word = {32'b0, halt_code};
                default: rd_word = '0;
            endcase
        end
    end

    assign rd_sh = rd_word >> {lane, 3'b000};

    always_comb begin
        case (memType[1:0])
            2'b00:   readData = memType[2] ? {56'b0, rd_sh[7:0]}  : {{56{rd_sh[7]}},  rd_sh[7:0]};
            2'b01:   readData = memType[2] ? {48'b0, rd_sh[15:0]} : {{48{rd_sh[15]}}, rd_sh[15:0]};
            2'b10:   readData = memType[2] ? {32'b0, rd_sh[31:0]} : {{32{rd_sh[31]}}, rd_sh[31:0]};
            default: readData = rd_sh;
        endcase
    end

    // A push into a full FIFO still fits when the head leaves in the same cycle.
    assign push_ok = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= writeData[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      count <= count + 1'b1;
            else if (pop && !push_ok) count <= count - 1'b1;
            if (push_req && !push_ok) overflow <= 1'b1;
        end
    end

    // Output handshake: a byte transfers on each rising edge where tx_valid && tx_ready;
    // while tx_valid is high and tx_ready low, tx_data holds its value.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: if (!empty) begin pop = 1'b1; state_d = SEND; end
            SEND: if (tx_ready) begin
                if (!empty) pop = 1'b1;
                else        state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            tx_data   <= 8'h00;
            halt      <= 1'b0;
            halt_code <= 32'h0;
        end else begin
            state_q <= state_d;
            if (pop) tx_data <= fifo_mem[rd_ptr];
            if (tohost_we) begin
                halt      <= 1'b1;
                halt_code <= writeData[31:0];
            end
        end
    end

    assign tx_valid = (state_q == SEND);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: table-driven load vectors, scoreboarded TX byte stream,
// and hand-written sequences for FIFO overflow, tohost and reset mid-transfer.
module tb_dmem_responder;
    localparam int          MEM_WORDS  = 4096;
    localparam logic [63:0] MMIO_BASE  = 64'h0000_0000_1000_0000;
    localparam int          FIFO_DEPTH = 8;
    localparam logic [63:0] TXDATA     = MMIO_BASE;
    localparam logic [63:0] TXSTATUS   = MMIO_BASE + 64'h8;
    localparam logic [63:0] TOHOST     = MMIO_BASE + 64'h10;

    logic        clk, reset;
    logic [63:0] addr, writeData, readData;
    logic        memWrite;
    logic [2:0]  memType;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready, halt;
    logic [31:0] halt_code;

    dmem_responder #(
        .MEM_WORDS(MEM_WORDS), .MMIO_BASE(MMIO_BASE), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .addr(addr), .writeData(writeData),
        .memWrite(memWrite), .memType(memType), .readData(readData),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .halt(halt), .halt_code(halt_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  mon_exp;
    logic [63:0] rd;

    typedef struct {
        logic [63:0] a;
        logic [2:0]  t;
        logic [63:0] exp;
    } vec_t;
    vec_t vecs[22];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic store(input logic [63:0] a, input logic [63:0] d, input logic [2:0] t);
        addr = a; writeData = d; memType = t; memWrite = 1'b1;
        @(posedge clk); #1;
        memWrite = 1'b0;
    endtask

    task automatic load(input logic [63:0] a, input logic [2:0] t, output logic [63:0] d);
        addr = a; memType = t; memWrite = 1'b0;
        #1 d = readData;
        @(posedge clk); #1;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit accepted);
        if (accepted) exp_q.push_back(b);
        store(TXDATA, {32'($urandom), 24'($urandom), b}, 3'b000);
    endtask

    // Scoreboard: every byte transferred on the output is popped and compared.
    always @(negedge clk) begin
        if (reset && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_extra: got 0x%0h expected no byte", tx_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("tx_byte", {56'b0, tx_data}, {56'b0, mon_exp});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{64'h107, 3'b000, 64'hFFFF_FFFF_FFFF_FF88};
        vecs[1]  = '{64'h107, 3'b100, 64'h0000_0000_0000_0088};
        vecs[2]  = '{64'h106, 3'b001, 64'hFFFF_FFFF_FFFF_8877};
        vecs[3]  = '{64'h106, 3'b101, 64'h0000_0000_0000_8877};
        vecs[4]  = '{64'h104, 3'b010, 64'hFFFF_FFFF_8877_6655};
        vecs[5]  = '{64'h104, 3'b110, 64'h0000_0000_8877_6655};
        vecs[6]  = '{64'h100, 3'b011, 64'h8877_6655_4433_2211};
        vecs[7]  = '{64'h100, 3'b111, 64'h8877_6655_4433_2211};
        vecs[8]  = '{64'h101, 3'b001, 64'h0000_0000_0000_2211};
        vecs[9]  = '{64'h103, 3'b010, 64'h0000_0000_4433_2211};
        vecs[10] = '{64'h105, 3'b011, 64'h8877_6655_4433_2211};
        vecs[11] = '{64'h102, 3'b001, 64'h0000_0000_0000_4433};
        vecs[12] = '{64'h200, 3'b011, 64'h0000_0000_AB00_0000};
        vecs[13] = '{64'h200 + MEM_WORDS * 8, 3'b011, 64'h0000_0000_AB00_0000};
        vecs[14] = '{64'h203, 3'b000, 64'hFFFF_FFFF_FFFF_FFAB};
        vecs[15] = '{64'h1001_0100, 3'b011, 64'h0};
        vecs[16] = '{64'h8000_0000_0000_0100, 3'b011, 64'h0};
        vecs[17] = '{64'h7FF8, 3'b011, 64'h0123_4567_89AB_CDEF};
        vecs[18] = '{MMIO_BASE - 64'h8, 3'b011, 64'h0123_4567_89AB_CDEF};
        vecs[19] = '{MMIO_BASE + 64'h18, 3'b011, 64'h0};
        vecs[20] = '{64'h105, 3'b000, 64'h0000_0000_0000_0066};
        vecs[21] = '{TXDATA, 3'b011, 64'h0};

        reset = 1'b0; memWrite = 1'b0; addr = '0; writeData = '0; memType = 3'b011; tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        check("rst_tx_valid", {63'b0, tx_valid}, 64'h0);
        check("rst_tx_data", {56'b0, tx_data}, 64'h0);
        check("rst_halt", {63'b0, halt}, 64'h0);
        check("rst_halt_code", {32'b0, halt_code}, 64'h0);
        load(TXSTATUS, 3'b011, rd);
        check("rst_status", rd, 64'h02);

        store(64'h100, 64'h8877_6655_4433_2211, 3'b011);
        store(64'h200, 64'h0, 3'b011);
        store(64'h203, 64'hFFFF_FFFF_FFFF_FFAB, 3'b000);
        store(64'h1001_0100, 64'hFFFF_FFFF_FFFF_FFFF, 3'b011);
        store(64'h8000_0000_0000_0100, 64'hFFFF_FFFF_FFFF_FFFF, 3'b011);
        store(64'h0FFF_FFF8, 64'h0123_4567_89AB_CDEF, 3'b011);

        for (int i = 0; i < 22; i++) begin
            load(vecs[i].a, vecs[i].t, rd);
            check($sformatf("vec%0d", i), rd, vecs[i].exp);
        end

        // "Hi" with the sink always ready
        tx_ready = 1'b1;
        push_byte(8'h48, 1'b1);
        check("hi_valid_after_push", {63'b0, tx_valid}, 64'h0);
        push_byte(8'h69, 1'b1);
        check("hi_valid_2nd_edge", {63'b0, tx_valid}, 64'h1);
        check("hi_first_byte", {56'b0, tx_data}, 64'h48);
        repeat (4) @(posedge clk);
        #1;
        check("hi_drained", 64'(exp_q.size()), 64'h0);
        check("hi_idle", {63'b0, tx_valid}, 64'h0);
        load(TXSTATUS, 3'b011, rd);
        check("hi_status", rd, 64'h02);

        // Overflow with the sink stalled
        tx_ready = 1'b0;
        for (int i = 0; i < 10; i++) push_byte(8'h30 + 8'(i), i < 9);
        check("ovf_valid", {63'b0, tx_valid}, 64'h1);
        check("ovf_head", {56'b0, tx_data}, 64'h30);
        load(TXSTATUS, 3'b011, rd);
        check("ovf_status", rd, 64'h85);
        repeat (3) @(posedge clk);
        #1 check("ovf_hold", {56'b0, tx_data}, 64'h30);

        // Push into a full FIFO on the cycle the output accepts a byte
        tx_ready = 1'b1;
        push_byte(8'h3A, 1'b1);
        tx_ready = 1'b0;
        check("full_swap_head", {56'b0, tx_data}, 64'h31);
        load(TXSTATUS, 3'b011, rd);
        check("full_swap_status", rd, 64'h85);

        tx_ready = 1'b1;
        begin
            int k;
            k = 0;
            while ((exp_q.size() != 0 || tx_valid) && k < 40) begin
                @(posedge clk);
                #1 k++;
            end
        end
        check("drain_left", 64'(exp_q.size()), 64'h0);
        check("drain_idle", {63'b0, tx_valid}, 64'h0);
        load(TXSTATUS, 3'b011, rd);
        check("drain_status", rd, 64'h06);

        // tohost
        store(TOHOST, 64'h0000_0000_0000_0001, 3'b010);
        check("halt_set", {63'b0, halt}, 64'h1);
        check("halt_code1", {32'b0, halt_code}, 64'h1);
        store(TOHOST, 64'hDEAD_BEEF_CAFE_F00D, 3'b011);
        check("halt_sticky", {63'b0, halt}, 64'h1);
        check("halt_code2", {32'b0, halt_code}, 64'hCAFE_F00D);
        load(TOHOST, 3'b010, rd);
        check("tohost_lw", rd, 64'hFFFF_FFFF_CAFE_F00D);
        load(TOHOST, 3'b011, rd);
        check("tohost_ld", rd, 64'h0000_0000_CAFE_F00D);

        // Reset in the middle of a stalled transfer
        tx_ready = 1'b0;
        push_byte(8'h55, 1'b1);
        push_byte(8'h66, 1'b1);
        check("pre_reset_valid", {63'b0, tx_valid}, 64'h1);
        #2 reset = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_valid", {63'b0, tx_valid}, 64'h0);
        check("mid_rst_data", {56'b0, tx_data}, 64'h0);
        check("mid_rst_halt", {63'b0, halt}, 64'h0);
        check("mid_rst_code", {32'b0, halt_code}, 64'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        tx_ready = 1'b1;
        load(TXSTATUS, 3'b011, rd);
        check("post_rst_status", rd, 64'h02);
        load(64'h100, 3'b011, rd);
        check("post_rst_ram", rd, 64'h8877_6655_4433_2211);
        repeat (3) @(posedge clk);
        #1 check("post_rst_idle", {63'b0, tx_valid}, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
